// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the memory arbiter slice.
// Optional feature macro used by the arbiter files: MEM_ARB_DPRIO_EN.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, ACCESS} arb_state_t;

  localparam int MEM_ARB_NREQ = 4;
  localparam int MEM_ARB_BLK  = 2;

  // Index width for a field that must address n entries, never narrower than one bit
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection for the memory arbiter.
// With MEM_ARB_DPRIO_EN defined, requesters in prioMask_i beat all others;
// round-robin order still applies inside whichever group wins.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter  int N_REQ = MEM_ARB_NREQ,
  localparam int PTR_W = idxWidth(N_REQ)
) (
`ifdef MEM_ARB_DPRIO_EN
  input  logic [N_REQ-1:0] prioMask_i,
`endif
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [PTR_W-1:0] winIdx_o,
  output logic             anyReq_o
);

  logic [N_REQ-1:0] pool;
  logic             found;
  int               cand;

  // Narrow the candidate pool to the priority group whenever that group is asking
  always_comb begin
`ifdef MEM_ARB_DPRIO_EN
    pool = ((req_i & prioMask_i) != '0) ? (req_i & prioMask_i) : req_i;
`else
    pool = req_i;
`endif
  end

  // Scan upward from the pointer with wrap-around and keep the first requester found
  always_comb begin
    winner_o = '0;
    winIdx_o = '0;
    found    = 1'b0;
    cand     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && pool[PTR_W'(cand)]) begin
        found                     = 1'b1;
        winner_o[PTR_W'(cand)]    = 1'b1;
        winIdx_o                  = PTR_W'(cand);
      end
    end
  end

  assign anyReq_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port among N_REQ cache requesters, one fixed-length
// burst of BLK_WORDS words at a time, granted in round-robin order.
// Optional feature macro: MEM_ARB_DPRIO_EN (dcache requests, odd indices, win over icache).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int N_REQ     = MEM_ARB_NREQ,
  parameter  int BLK_WORDS = MEM_ARB_BLK,
  localparam int IDX_W     = idxWidth(BLK_WORDS),
  localparam int PTR_W     = idxWidth(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       wen,
  input  logic [N_REQ-1:0][31:0] addr,
  input  logic [N_REQ-1:0][31:0] wdata,
  input  logic                   ram_ready,
  input  word_t                  ram_rdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]       word_idx,
  output logic [N_REQ-1:0]       word_ack,
  output logic [N_REQ-1:0]       done,
  output word_t                  rdata,
  output word_t                  ramaddr,
  output logic                   ramren,
  output logic                   ramwen,
  output word_t                  ramstore
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] gIdx_q, gIdx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] winner;
  logic [PTR_W-1:0] winIdx;
  logic             anyReq;
  logic             lastWord;
  logic [PTR_W-1:0] nextPtr;
  logic             active;
  logic             unusedAddrLow;

  // Byte-offset bits of the burst addresses are ignored; the RAM is word addressed
  assign unusedAddrLow = ^addr;

  assign lastWord = (cnt_q == IDX_W'(BLK_WORDS - 1));
  assign nextPtr  = (gIdx_q == PTR_W'(N_REQ - 1)) ? '0 : gIdx_q + 1'b1;
  assign active   = (state_q == ACCESS);

`ifdef MEM_ARB_DPRIO_EN
  logic [N_REQ-1:0] dcacheMask;

  // Odd requester indices are the dcaches
  always_comb begin
    dcacheMask = '0;
    for (int i = 1; i < N_REQ; i += 2) dcacheMask[i] = 1'b1;
  end
`endif

  rr_pick #(.N_REQ(N_REQ)) picker (
`ifdef MEM_ARB_DPRIO_EN
    .prioMask_i (dcacheMask),
`endif
    .req_i      (req),
    .ptr_i      (ptr_q),
    .winner_o   (winner),
    .winIdx_o   (winIdx),
    .anyReq_o   (anyReq)
  );

  // State, grant, word counter and round-robin pointer registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gIdx_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gIdx_q  <= gIdx_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Grant on any request; leave ACCESS on the last word (advancing the pointer) or on abort
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gIdx_d  = gIdx_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d = ACCESS;
          gnt_d   = winner;
          gIdx_d  = winIdx;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (ram_ready && lastWord) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = nextPtr;
        end else if (!req[gIdx_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (ram_ready) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM request signals and per-requester handshakes for the granted burst
  always_comb begin
    gnt      = gnt_q;
    word_idx = cnt_q;
    rdata    = ram_rdata;
    ramren   = active & ~wen[gIdx_q];
    ramwen   = active & wen[gIdx_q];
    ramaddr  = active ? {addr[gIdx_q][31:2] + 30'(cnt_q), 2'b00} : '0;
    ramstore = active ? wdata[gIdx_q] : '0;
    word_ack = ram_ready ? gnt_q : '0;
    done     = (ram_ready && lastWord) ? gnt_q : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table, hand-written multi-cycle
// sequences, then randomized traffic against a behavioural model.
// Honours MEM_ARB_DPRIO_EN for the expected grant order.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int N   = MEM_ARB_NREQ;
  localparam int BLK = MEM_ARB_BLK;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [N-1:0]        req = '0;
  logic [N-1:0]        wen = '0;
  logic [N-1:0][31:0]  addr = '0;
  logic [N-1:0][31:0]  wdata = '0;
  logic                ram_ready = 1'b0;
  word_t               ram_rdata = '0;
  logic [N-1:0]        gnt;
  logic [0:0]          word_idx;
  logic [N-1:0]        word_ack;
  logic [N-1:0]        done;
  word_t               rdata;
  word_t               ramaddr;
  logic                ramren;
  logic                ramwen;
  word_t               ramstore;

  int checkCount = 0;
  int passCount  = 0;

  logic [N-1:0][31:0] tbAddr  = '0;
  logic [N-1:0][31:0] tbWdata = '0;

  mem_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .ram_ready (ram_ready),
    .ram_rdata (ram_rdata),
    .gnt       (gnt),
    .word_idx  (word_idx),
    .word_ack  (word_ack),
    .done      (done),
    .rdata     (rdata),
    .ramaddr   (ramaddr),
    .ramren    (ramren),
    .ramwen    (ramwen),
    .ramstore  (ramstore)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs just after the falling edge, then settle before checking
  task automatic applyStimulus(input logic rst, input logic [N-1:0] r, input logic [N-1:0] w,
                               input logic rdy, input logic [N-1:0][31:0] a,
                               input logic [N-1:0][31:0] d, input word_t rd);
    @(negedge CLK);
    RST       = rst;
    req       = r;
    wen       = w;
    ram_ready = rdy;
    addr      = a;
    wdata     = d;
    ram_rdata = rd;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
  endtask

  function automatic logic [N-1:0] oneHot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference: first requester at or above the pointer, wrapping; dcaches first when enabled
  function automatic int pickWinner(input logic [N-1:0] r, input int p);
    logic [N-1:0] pool;
`ifdef MEM_ARB_DPRIO_EN
    logic [N-1:0] dc;
`endif
    int i;
    pool = r;
`ifdef MEM_ARB_DPRIO_EN
    dc = '0;
    for (int k = 1; k < N; k += 2) dc[k] = r[k];
    if (dc != '0) pool = dc;
`endif
    for (int off = 0; off < N; off++) begin
      i = (p + off) % N;
      if (pool[i]) return i;
    end
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wen;
    logic         rdy;
    logic [31:0]  base;
    logic [N-1:0] expGnt;
    logic         expRen;
    logic         expWen;
    logic [31:0]  expAddr;
    logic [N-1:0] expAck;
    logic [N-1:0] expDone;
    logic [31:0]  expIdx;
  } vec_t;

  vec_t vecs[8];
  int   expOrder[5];

  bit          mBusy;
  int          mOwner;
  int          mWord;
  int          mPtr;

  initial begin
    // field order: req, wen, rdy, base, expGnt, expRen, expWen, expAddr, expAck, expDone, expIdx
    vecs[0] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_0100, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'd0};
    vecs[1] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_0100, 4'b0010, 1'b1, 1'b0, 32'h0000_0100, 4'b0010, 4'b0000, 32'd0};
    vecs[2] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_0100, 4'b0010, 1'b1, 1'b0, 32'h0000_0104, 4'b0010, 4'b0010, 32'd1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b1, 32'h0000_0100, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'd0};
    vecs[4] = '{4'b0001, 4'b0000, 1'b0, 32'hFFFF_FFFC, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'd0};
    vecs[5] = '{4'b0001, 4'b0000, 1'b1, 32'hFFFF_FFFC, 4'b0001, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'b0001, 4'b0000, 32'd0};
    vecs[6] = '{4'b0001, 4'b0000, 1'b1, 32'hFFFF_FFFC, 4'b0001, 1'b1, 1'b0, 32'h0000_0000, 4'b0001, 4'b0001, 32'd1};
    vecs[7] = '{4'b0000, 4'b0000, 1'b0, 32'hFFFF_FFFC, 4'b0000, 1'b0, 1'b0, 32'h0, 4'b0000, 4'b0000, 32'd0};
`ifdef MEM_ARB_DPRIO_EN
    expOrder = '{1, 3, 1, 3, 1};
`else
    expOrder = '{0, 1, 2, 3, 0};
`endif

    // Reset state
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("reset gnt", gnt, '0);
    checkOutput("reset ramren", ramren, '0);
    checkOutput("reset ramwen", ramwen, '0);
    checkOutput("reset word_ack", word_ack, '0);
    checkOutput("reset done", done, '0);
    checkOutput("reset word_idx", word_idx, '0);

    // Single read burst followed by an address-wrap burst
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) tbAddr[k] = vecs[i].base;
      applyStimulus(1'b0, vecs[i].req, vecs[i].wen, vecs[i].rdy, tbAddr, tbWdata, 32'h1234_0000 + i);
      checkOutput($sformatf("vec%0d gnt", i), gnt, vecs[i].expGnt);
      checkOutput($sformatf("vec%0d ramren", i), ramren, vecs[i].expRen);
      checkOutput($sformatf("vec%0d ramwen", i), ramwen, vecs[i].expWen);
      checkOutput($sformatf("vec%0d word_ack", i), word_ack, vecs[i].expAck);
      checkOutput($sformatf("vec%0d done", i), done, vecs[i].expDone);
      checkOutput($sformatf("vec%0d word_idx", i), word_idx, vecs[i].expIdx);
      checkOutput($sformatf("vec%0d rdata", i), rdata, 32'h1234_0000 + i);
      if (vecs[i].expGnt != '0) checkOutput($sformatf("vec%0d ramaddr", i), ramaddr, vecs[i].expAddr);
    end

    // Write burst on requester 2 with ram_ready every third cycle
    for (int k = 0; k < N; k++) tbWdata[k] = 32'hDEAD_0000 + k;
    tbAddr[2]  = 32'h0000_0200;
    tbWdata[2] = 32'hA;
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("wr idle gnt", gnt, '0);
    for (int c = 1; c <= 6; c++) begin
      int wordNo;
      wordNo     = (c <= 3) ? 0 : 1;
      tbWdata[2] = (wordNo == 0) ? 32'hA : 32'hB;
      applyStimulus(1'b0, 4'b0100, 4'b0100, (c % 3) == 0, tbAddr, tbWdata, '0);
      checkOutput($sformatf("wr c%0d gnt", c), gnt, 4'b0100);
      checkOutput($sformatf("wr c%0d ramwen", c), ramwen, 1'b1);
      checkOutput($sformatf("wr c%0d ramren", c), ramren, 1'b0);
      checkOutput($sformatf("wr c%0d ramstore", c), ramstore, (wordNo == 0) ? 32'hA : 32'hB);
      checkOutput($sformatf("wr c%0d ramaddr", c), ramaddr, 32'h200 + 4 * wordNo);
      checkOutput($sformatf("wr c%0d word_idx", c), word_idx, wordNo);
      checkOutput($sformatf("wr c%0d done", c), done, (c == 6) ? 4'b0100 : 4'b0000);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("wr end gnt", gnt, '0);
    checkOutput("wr end ramwen", ramwen, 1'b0);

    // Contention with every requester held high from a fresh pointer
    for (int k = 0; k < N; k++) tbAddr[k] = 32'h1000 * (k + 1);
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    for (int g = 0; g < 5; g++) begin
      applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, tbAddr, tbWdata, '0);
      checkOutput($sformatf("rr%0d gap gnt", g), gnt, '0);
      applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, tbAddr, tbWdata, '0);
      checkOutput($sformatf("rr%0d gnt", g), gnt, oneHot(expOrder[g]));
      applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b1, tbAddr, tbWdata, '0);
      checkOutput($sformatf("rr%0d done", g), done, oneHot(expOrder[g]));
    end

    // Abort: requester 0 drops after its first word; pointer must stay at 0
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1, tbAddr, tbWdata, '0);
    checkOutput("abort word0 ack", word_ack, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("abort drop done", done, '0);
    checkOutput("abort drop word_idx", word_idx, 1'b1);
    applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("abort idle gnt", gnt, '0);
    applyStimulus(1'b0, 4'b0101, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("abort ptr kept gnt", gnt, 4'b0001);

    // Reset in the middle of a burst, then a fresh request restarts at word 0
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1, tbAddr, tbWdata, '0);
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("rst mid gnt", gnt, '0);
    checkOutput("rst mid ramren", ramren, 1'b0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0, tbAddr, tbWdata, '0);
    checkOutput("rst restart gnt", gnt, 4'b0010);
    checkOutput("rst restart word_idx", word_idx, 1'b0);
    checkOutput("rst restart ramren", ramren, 1'b1);

    // Randomized traffic against the behavioural model
    applyStimulus(1'b1, '0, '0, 1'b0, tbAddr, tbWdata, '0);
    mBusy = 1'b0; mOwner = 0; mWord = 0; mPtr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic         rRst;
      logic [N-1:0] rReq;
      logic [N-1:0] rWen;
      logic         rRdy;
      word_t        rRd;
      logic [N-1:0] expGnt;
      logic [29:0]  wordAddr;
      int           w;
      rRst = ($urandom_range(0, 199) == 0);
      rRdy = ($urandom_range(0, 2) != 0);
      rRd  = $urandom();
      rWen = wen;
      for (int k = 0; k < N; k++) begin
        tbWdata[k] = $urandom();
        if (mBusy && k == mOwner) begin
          rReq[k] = ($urandom_range(0, 19) != 0);
        end else begin
          rReq[k] = ($urandom_range(0, 2) != 0);
          rWen[k] = $urandom_range(0, 1);
          tbAddr[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
        end
      end
      applyStimulus(rRst, rReq, rWen, rRdy, tbAddr, tbWdata, rRd);

      expGnt = mBusy ? oneHot(mOwner) : '0;
      checkOutput("rnd gnt", gnt, expGnt);
      checkOutput("rnd word_idx", word_idx, mBusy ? mWord : 0);
      checkOutput("rnd ramren", ramren, mBusy && !rWen[mOwner]);
      checkOutput("rnd ramwen", ramwen, mBusy && rWen[mOwner]);
      checkOutput("rnd word_ack", word_ack, rRdy ? expGnt : '0);
      checkOutput("rnd done", done, (rRdy && mWord == BLK - 1) ? expGnt : '0);
      checkOutput("rnd rdata", rdata, rRd);
      if (mBusy) begin
        wordAddr = tbAddr[mOwner][31:2] + 30'(mWord);
        checkOutput("rnd ramaddr", ramaddr, {wordAddr, 2'b00});
        checkOutput("rnd ramstore", ramstore, tbWdata[mOwner]);
      end

      if (rRst) begin
        mBusy = 1'b0; mWord = 0; mPtr = 0;
      end else if (!mBusy) begin
        w = pickWinner(rReq, mPtr);
        if (w >= 0) begin
          mBusy = 1'b1; mOwner = w; mWord = 0;
        end
      end else if (rRdy && mWord == BLK - 1) begin
        mBusy = 1'b0; mWord = 0; mPtr = (mOwner + 1) % N;
      end else if (!rReq[mOwner]) begin
        mBusy = 1'b0; mWord = 0;
      end else if (rRdy) begin
        mWord++;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
